// File: rtl/minisys_io_pkg.sv
// Shared keypad IO definitions: scanner FSM states, CPU register
// offsets, status bit positions and a column-decode helper.
package minisys_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_SCAN,
        ST_LATCH,
        ST_RELEASE
    } key_state_e;

    localparam logic [1:0] KEYVAL_OFF  = 2'b00;
    localparam logic [1:0] KEYSTAT_OFF = 2'b10;

    localparam int STAT_VALID_BIT   = 0;
    localparam int STAT_OVERRUN_BIT = 1;

    // Index of the lowest active-low column bit.
    function automatic logic [1:0] low_zero_idx(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating stable-cycle counter shared by press and release debounce.
// Ports: clock, reset (async high), clr, en -> done (next en cycle is the CNT-th).
module key_debounce
    import minisys_io_pkg::*;
#(
    parameter int unsigned CNT = 200000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned W = $clog2(CNT + 1);
    localparam logic [W-1:0] MAX = W'(CNT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Not gated by en so the caller can use it to pick clr instead.
    assign done = (cnt_q >= (MAX - 1'b1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan16.sv
// 4x4 keypad scanner with debounce and CPU-readable KEYVAL/KEYSTAT.
// Ports: clock, reset (async high), col/line keypad pins, keycs/addr/ior
// CPU read side, ioread_data; key_int exists only with KEYPAD_IRQ_EN.
module keypad_scan16
    import minisys_io_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col,
    output logic [3:0]  line,
    input  logic        keycs,
    input  logic [1:0]  addr,
    input  logic        ior,
    output logic [15:0] ioread_data
`ifdef KEYPAD_IRQ_EN
    ,
    output logic        key_int
`endif
);

    localparam int unsigned DW = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    key_state_e state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    hit_q, hit_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic db_clr;
    logic db_en;
    logic db_done;
    logic rd_keyval;
    logic rd_keystat;
    logic pressed;

    assign pressed    = (col != 4'hF);
    assign rd_keyval  = keycs && ior && (addr == KEYVAL_OFF);
    assign rd_keystat = keycs && ior && (addr == KEYSTAT_OFF);

    key_debounce #(.CNT(DEBOUNCE_CNT)) u_db (
        .clock (clock),
        .reset (reset),
        .clr   (db_clr),
        .en    (db_en),
        .done  (db_done)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        div_d   = div_q;
        hit_d   = hit_q;
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        line    = 4'b0000;
        db_clr  = 1'b0;
        db_en   = 1'b0;
        // Read side-effects first so a LATCH below overrides them.
        if (rd_keyval) valid_d = 1'b0;
        if (rd_keystat) ovr_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                db_clr = 1'b1;
                if (pressed) state_d = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!pressed) begin
                    db_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (db_done) begin
                    db_clr  = 1'b1;
                    row_d   = 2'd0;
                    div_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    db_en = 1'b1;
                end
            end
            ST_SCAN: begin
                line = ~(4'b0001 << row_q);
                if (div_q == DIV_LAST) begin
                    if (pressed) begin
                        hit_d   = {row_q, low_zero_idx(col)};
                        state_d = ST_LATCH;
                    end else if (row_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + 2'd1;
                        div_d = '0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LATCH: begin
                code_d  = hit_q;
                valid_d = 1'b1;
                if (valid_q) ovr_d = 1'b1;
                db_clr  = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (pressed) begin
                    db_clr = 1'b1;
                end else if (db_done) begin
                    db_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    db_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ioread_data = 16'h0000;
        if (keycs && ior) begin
            case (addr)
                KEYVAL_OFF: ioread_data = {12'h000, code_q};
                KEYSTAT_OFF: begin
                    ioread_data[STAT_VALID_BIT]   = valid_q;
                    ioread_data[STAT_OVERRUN_BIT] = ovr_q;
                end
                default: ioread_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= 2'd0;
            div_q   <= '0;
            hit_q   <= 4'h0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            div_q   <= div_d;
            hit_q   <= hit_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic irq_q;
    logic irq_d;

    assign irq_d   = (state_q == ST_LATCH);
    assign key_int = irq_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan16.sv
// Directed self-checking bench for keypad_scan16 (SCAN_DIV=4, DEBOUNCE_CNT=8)
// with a behavioural keypad matrix model driving col from line.
module tb_keypad_scan16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col;
    logic [3:0]  line;
    logic        keycs = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic        ior = 1'b0;
    logic [15:0] ioread_data;
`ifdef KEYPAD_IRQ_EN
    logic        key_int;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic       key_on = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic       frc_on = 1'b0;
    logic [3:0] frc_val = 4'hF;

    always #5 clock = ~clock;

    // A pressed key pulls its column low only while its row is driven.
    always_comb begin
        col = 4'hF;
        if (frc_on) col = frc_val;
        else if (key_on && !line[key_r]) col = ~(4'b0001 << key_c);
    end

    keypad_scan16 #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .col         (col),
        .line        (line),
        .keycs       (keycs),
        .addr        (addr),
        .ior         (ior),
        .ioread_data (ioread_data)
`ifdef KEYPAD_IRQ_EN
        ,
        .key_int     (key_int)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        keycs = 1'b1;
        ior   = 1'b1;
        addr  = a;
        #1;
        d = ioread_data;
        @(negedge clock);
        keycs = 1'b0;
        ior   = 1'b0;
        addr  = 2'b00;
    endtask

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_line(input logic [3:0] pat, input string nm);
        int n;
        n = 0;
        while (line !== pat && n < 200) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (line !== pat) begin
            miscompares++;
            $display("FAIL %s: got line %b want %b", nm, line, pat);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r  = r;
        key_c  = c;
        key_on = 1'b1;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        reset = 1'b1;
        cyc(3);
        vectors++;
        if (line !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_line: got %b want 0000", line);
        end
`ifdef KEYPAD_IRQ_EN
        vectors++;
        if (key_int !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_irq: got %b want 0", key_int);
        end
`endif
        reset = 1'b0;
        cyc(2);
        rd(2'b00, d);
        chk("reset_keyval", d, 16'h0000);
        rd(2'b10, d);
        chk("reset_keystat", d, 16'h0000);
        rd(2'b01, d);
        chk("reset_other_addr", d, 16'h0000);
    endtask

    task automatic test_single_key;
        logic [15:0] d;
        press(2'd2, 2'd1);
        wait_line(4'b1011, "single_row2_drive");
        cyc(30);
        key_on = 1'b0;
        cyc(20);
        rd(2'b10, d);
        chk("single_keystat", d, 16'h0001);
        rd(2'b00, d);
        chk("single_keyval", d, 16'h0009);
        rd(2'b10, d);
        chk("single_keystat_after_rd", d, 16'h0000);
    endtask

    task automatic test_bounce;
        logic [15:0] d;
        int scans;
        scans = 0;
        frc_val = 4'b1110;
        frc_on  = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (line !== 4'b0000) scans++;
        end
        frc_on = 1'b0;
        @(negedge clock);
        frc_on = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (line !== 4'b0000) scans++;
        end
        frc_on = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (line !== 4'b0000) scans++;
        end
        chk("bounce_no_scan", 16'(scans), 16'h0000);
        rd(2'b10, d);
        chk("bounce_keystat", d, 16'h0000);
    endtask

    task automatic test_overrun;
        logic [15:0] d;
        press(2'd0, 2'd0);
        wait_line(4'b1110, "ovr_row0_drive");
        cyc(25);
        key_on = 1'b0;
        cyc(20);
        press(2'd3, 2'd3);
        wait_line(4'b0111, "ovr_row3_drive");
        cyc(20);
        key_on = 1'b0;
        cyc(20);
        rd(2'b10, d);
        chk("ovr_keystat", d, 16'h0003);
        rd(2'b10, d);
        chk("ovr_keystat_cleared", d, 16'h0001);
        rd(2'b00, d);
        chk("ovr_keyval", d, 16'h000F);
        rd(2'b10, d);
        chk("ovr_keystat_final", d, 16'h0000);
    endtask

    task automatic test_multi_col;
        logic [15:0] d;
        frc_val = 4'b1001;
        frc_on  = 1'b1;
        cyc(40);
        frc_on = 1'b0;
        cyc(20);
        rd(2'b10, d);
        chk("multi_keystat", d, 16'h0001);
        rd(2'b00, d);
        chk("multi_lowest_col", d, 16'h0001);
    endtask

    task automatic test_reset_mid_scan;
        logic [15:0] d;
        press(2'd3, 2'd0);
        wait_line(4'b1101, "rst_row1_drive");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_line_async", {12'h000, line}, 16'h0000);
        key_on = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cyc(20);
        chk("rst_line_idle", {12'h000, line}, 16'h0000);
        rd(2'b10, d);
        chk("rst_keystat", d, 16'h0000);
        rd(2'b00, d);
        chk("rst_keyval", d, 16'h0000);
    endtask

    task automatic test_latch_read;
        logic [15:0] d;
        press(2'd1, 2'd2);
        wait_line(4'b1101, "lr_row1_drive");
        cyc(4);
        chk("lr_latch_line", {12'h000, line}, 16'h0000);
        rd(2'b00, d);
        chk("lr_old_code", d, 16'h0000);
        key_on = 1'b0;
        cyc(20);
        rd(2'b10, d);
        chk("lr_keystat", d, 16'h0001);
        rd(2'b00, d);
        chk("lr_keyval", d, 16'h0006);
    endtask

`ifdef KEYPAD_IRQ_EN
    task automatic test_irq;
        logic [15:0] d;
        int highs;
        highs = 0;
        press(2'd0, 2'd3);
        repeat (80) begin
            @(negedge clock);
            if (key_int === 1'b1) highs++;
        end
        chk("irq_pulse_cycles", 16'(highs), 16'h0001);
        key_on = 1'b0;
        cyc(20);
        rd(2'b00, d);
        chk("irq_keyval", d, 16'h0003);
    endtask
`endif

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_overrun();
        test_multi_col();
        test_reset_mid_scan();
        test_latch_read();
`ifdef KEYPAD_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
